// File: rtl/pipeline_flow_ctrl.sv
// Front-end pipeline registers (PC, IF/ID, ID/EX) with stall/flush handling and stallF watchdog.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_flow_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CTRL_W    = 16,
    parameter int unsigned MAX_STALL = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stallF_i,
    input  logic              stallD_i,
    input  logic              flushD_i,
    input  logic              flushE_i,
    input  logic [31:0]       pc_next_i,
    input  logic [31:0]       instr_F_i,
    input  logic [CTRL_W-1:0] ctrl_D_i,
    output logic [31:0]       pc_F_o,
    output logic [31:0]       pc_D_o,
    output logic [31:0]       instr_D_o,
    output logic              valid_D_o,
    output logic [31:0]       pc_E_o,
    output logic [CTRL_W-1:0] ctrl_E_o,
    output logic              valid_E_o,
    output logic              stall_timeout_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    localparam int unsigned      CNT_W   = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_COUNTING,
        WD_TRIPPED
    } wd_state_t;

    logic [31:0]       r_pc_F;
    logic [31:0]       r_pc_D;
    logic [31:0]       r_instr_D;
    logic              r_valid_D;
    logic [31:0]       r_pc_E;
    logic [CTRL_W-1:0] r_ctrl_E;
    logic              r_valid_E;

    wd_state_t         r_wd_state;
    wd_state_t         w_wd_state_nxt;
    logic [CNT_W-1:0]  r_wd_cnt;
    logic [CNT_W-1:0]  w_wd_cnt_nxt;
    logic [CNT_W-1:0]  w_wd_cnt_inc;
    logic              w_wd_hit;
    logic              r_timeout;

    // A redirect must never be lost under a concurrent load-use stall.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc_F <= RESET_PC;
        end else if (!stallF_i || flushD_i) begin
            r_pc_F <= pc_next_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flushD_i) begin
            r_instr_D <= NOP_INSTR;
            r_pc_D    <= '0;
            r_valid_D <= 1'b0;
        end else if (!stallD_i) begin
            r_instr_D <= instr_F_i;
            r_pc_D    <= r_pc_F;
            r_valid_D <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flushE_i) begin
            r_ctrl_E  <= '0;
            r_pc_E    <= '0;
            r_valid_E <= 1'b0;
        end else begin
            r_ctrl_E  <= ctrl_D_i;
            r_pc_E    <= r_pc_D;
            r_valid_E <= r_valid_D;
        end
    end

    assign w_wd_hit     = stallF_i & ~flushD_i;
    assign w_wd_cnt_inc = r_wd_cnt + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wd_state <= WD_IDLE;
            r_wd_cnt   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wd_state <= w_wd_state_nxt;
            r_wd_cnt   <= w_wd_cnt_nxt;
            r_timeout  <= (w_wd_state_nxt == WD_TRIPPED);
        end
    end

    always_comb begin
        w_wd_state_nxt = r_wd_state;
        w_wd_cnt_nxt   = r_wd_cnt;
        case (r_wd_state)
            WD_IDLE, WD_COUNTING: begin
                if (w_wd_hit) begin
                    w_wd_cnt_nxt   = w_wd_cnt_inc;
                    w_wd_state_nxt = (w_wd_cnt_inc == MAX_CNT) ? WD_TRIPPED : WD_COUNTING;
                end else begin
                    w_wd_cnt_nxt   = '0;
                    w_wd_state_nxt = WD_IDLE;
                end
            end
            WD_TRIPPED: begin
                w_wd_cnt_nxt   = MAX_CNT;
                w_wd_state_nxt = WD_TRIPPED;
            end
            default: begin
                w_wd_cnt_nxt   = '0;
                w_wd_state_nxt = WD_IDLE;
            end
        endcase
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stallD_i && !flushD_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flushD_i && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

    assign pc_F_o          = r_pc_F;
    assign pc_D_o          = r_pc_D;
    assign instr_D_o       = r_instr_D;
    assign valid_D_o       = r_valid_D;
    assign pc_E_o          = r_pc_E;
    assign ctrl_E_o        = r_ctrl_E;
    assign valid_E_o       = r_valid_E;
    assign stall_timeout_o = r_timeout;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Scoreboard bench for pipeline_flow_ctrl: the driver pushes the expected post-edge state,
// a negedge monitor pops and compares every output.
module tb_pipeline_flow_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          MAXS   = 8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, flushE = 1'b0;
    logic [31:0] pc_next = '0, instr_F = '0;
    logic [15:0] ctrl_D = '0;
    logic [31:0] pc_F, pc_D, instr_D, pc_E, stall_cnt, flush_cnt;
    logic        valid_D, valid_E, timeout;
    logic [15:0] ctrl_E;

    pipeline_flow_ctrl #(
        .RESET_PC (RST_PC),
        .CTRL_W   (16),
        .MAX_STALL(MAXS),
        .NOP_INSTR(NOP)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .stallF_i       (stallF),
        .stallD_i       (stallD),
        .flushD_i       (flushD),
        .flushE_i       (flushE),
        .pc_next_i      (pc_next),
        .instr_F_i      (instr_F),
        .ctrl_D_i       (ctrl_D),
        .pc_F_o         (pc_F),
        .pc_D_o         (pc_D),
        .instr_D_o      (instr_D),
        .valid_D_o      (valid_D),
        .pc_E_o         (pc_E),
        .ctrl_E_o       (ctrl_E),
        .valid_E_o      (valid_E),
        .stall_timeout_o(timeout),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] pcF, pcD, instrD, pcE, sc, fc;
        logic        vD, vE, to;
        logic [15:0] ctrlE;
    } exp_t;

    exp_t q[$];
    exp_t m;      // model's view of the outputs after the last issued edge
    exp_t e;
    int   run_len = 0;
    int   cyc_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc_cnt, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            e = q.pop_front();
            chk("pc_F",      pc_F,             e.pcF);
            chk("pc_D",      pc_D,             e.pcD);
            chk("instr_D",   instr_D,          e.instrD);
            chk("valid_D",   {31'd0, valid_D}, {31'd0, e.vD});
            chk("pc_E",      pc_E,             e.pcE);
            chk("ctrl_E",    {16'd0, ctrl_E},  {16'd0, e.ctrlE});
            chk("valid_E",   {31'd0, valid_E}, {31'd0, e.vE});
            chk("timeout",   {31'd0, timeout}, {31'd0, e.to});
            chk("stall_cnt", stall_cnt,        e.sc);
            chk("flush_cnt", flush_cnt,        e.fc);
        end
    end

    // One cycle of stimulus; expected state after the coming edge is derived from the rules.
    task automatic drive(input bit rst, input bit sF, input bit sD, input bit fD, input bit fE,
                         input logic [31:0] pcn);
        exp_t nx;
        @(posedge clk);
        #1;
        rst_n   = ~rst;
        stallF  = sF;
        stallD  = sD;
        flushD  = fD;
        flushE  = fE;
        pc_next = pcn;
        instr_F = $urandom;
        ctrl_D  = 16'($urandom);
        nx = m;
        if (rst) begin
            nx.pcF = RST_PC; nx.pcD = 0; nx.instrD = NOP; nx.vD = 0;
            nx.pcE = 0; nx.ctrlE = 0; nx.vE = 0; nx.to = 0; nx.sc = 0; nx.fc = 0;
            run_len = 0;
        end else begin
            if (!sF || fD) nx.pcF = pcn;
            if (fD) begin
                nx.instrD = NOP; nx.pcD = 0; nx.vD = 0;
            end else if (!sD) begin
                nx.instrD = instr_F; nx.pcD = m.pcF; nx.vD = 1;
            end
            if (fE) begin
                nx.ctrlE = 0; nx.pcE = 0; nx.vE = 0;
            end else begin
                nx.ctrlE = ctrl_D; nx.pcE = m.pcD; nx.vE = m.vD;
            end
            if (sF && !fD) run_len++;
            else           run_len = 0;
            if (run_len >= MAXS) nx.to = 1;
`ifdef PIPE_PERF_CNT_EN
            if (sD && !fD && m.sc != 32'hFFFF_FFFF) nx.sc = m.sc + 1;
            if (fD && m.fc != 32'hFFFF_FFFF)        nx.fc = m.fc + 1;
`endif
        end
        nx.cyc = cyc_cnt + 1;
        m = nx;
        q.push_back(nx);
    endtask

    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, m.pcF + 32'd4);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        m = '{default: '0};
        do_reset();
        run_free(4);
        drive(0, 1, 1, 0, 1, m.pcF + 32'd4);          // load-use bubble
        run_free(3);
        drive(0, 0, 0, 1, 1, 32'h0000_0200);          // taken branch
        run_free(3);
        drive(0, 1, 1, 1, 0, 32'h0000_0300);          // redirect beats stall
        run_free(3);
        for (int i = 0; i < MAXS - 1; i++) drive(0, 1, 1, 0, 0, m.pcF + 32'd4);
        run_free(2);
        for (int i = 0; i < MAXS; i++) drive(0, 1, 1, 0, 0, m.pcF + 32'd4);
        run_free(4);
        do_reset();
        run_free(2);
        for (int i = 0; i < 3000; i++) begin
            bit r, sF, sD, fD, fE;
            logic [31:0] pcn;
            if ($urandom_range(0, 49) == 0) begin
                int len = $urandom_range(MAXS - 2, MAXS + 2);
                for (int k = 0; k < len; k++) drive(0, 1, $urandom_range(0, 1) == 0, 0, 0, m.pcF + 32'd4);
            end
            r   = ($urandom_range(0, 199) == 0);
            sF  = ($urandom_range(0, 3) == 0);
            sD  = sF ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            fD  = ($urandom_range(0, 7) == 0);
            fE  = ($urandom_range(0, 5) == 0);
            pcn = fD ? ($urandom & 32'hFFFF_FFFC) : (m.pcF + 32'd4);
            drive(r, sF, sD, fD, fE, pcn);
        end
        repeat (4) @(negedge clk);
        chk("queue_drain", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
